// File: rtl/cpu_pkg.sv
// Shared types for the memory arbiter: FSM states, transaction owner and
// the default data/address width.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Grant vector bit positions shared by rr_arb2 and the arbiter top.
    localparam int GNT_IF = 0;
    localparam int GNT_LS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Generic request/response bus. The master side issues requests and
// consumes responses; the slave side accepts requests and returns data.
interface mem_arbiter_if #(
    parameter int xlen = cpu_pkg::XLEN_DEFAULT
) ();

    logic              req_valid;
    logic [xlen-1:0]   req_addr;
    logic              req_we;
    logic [xlen-1:0]   req_wdata;
    logic [xlen/8-1:0] req_be;
    logic              req_ready;
    logic              resp_valid;
    logic [xlen-1:0]   resp_data;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_be,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_be,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection. Bit 0 is the fetch requester,
// bit 1 the load/store requester; the grant is one-hot or all-zero.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_grant,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the side that lost last time goes.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == OWN_LS) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single memory port between instruction fetch and load/store with
// at most one transaction in flight. A request is accepted in IDLE, presented
// to memory in ISSUE until memory takes it, and completed in WAIT when memory
// answers; the answer is forwarded combinationally to whoever owns the slot.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int xlen = XLEN_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  if_bus,
    mem_arbiter_if.slave  ls_bus,
    mem_arbiter_if.master mem_bus
);

    localparam int BEW = xlen / 8;

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    owner_e          last_q, last_d;
    logic            req_valid_q, req_valid_d;
    logic [xlen-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [xlen-1:0] wdata_q, wdata_d;
    logic [BEW-1:0]  be_q, be_d;

    logic [1:0]      req_vec;
    logic [1:0]      gnt;
    logic            in_idle;
    logic            resp_fire;
    logic            if_resp_hit;
    logic            ls_resp_hit;

    // The fetch side never writes, so its write fields are deliberately ignored.
    logic            unused_if_fields;
    assign unused_if_fields = ^{if_bus.req_we, if_bus.req_wdata, if_bus.req_be};

    assign req_vec = {ls_bus.req_valid, if_bus.req_valid};

    rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last_grant (last_q),
        .gnt        (gnt)
    );

    assign in_idle     = (state_q == IDLE);
    assign resp_fire   = (state_q == WAIT) && mem_bus.resp_valid;
    assign if_resp_hit = resp_fire && (owner_q == OWN_IF);
    assign ls_resp_hit = resp_fire && (owner_q == OWN_LS);

    // Next-state and next-field computation for the issue FSM.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        case (state_q)
            IDLE: begin
                if (gnt[GNT_IF]) begin
                    owner_d     = OWN_IF;
                    last_d      = OWN_IF;
                    addr_d      = if_bus.req_addr;
                    we_d        = 1'b0;
                    wdata_d     = '0;
                    be_d        = '0;
                    req_valid_d = 1'b1;
                    state_d     = ISSUE;
                end else if (gnt[GNT_LS]) begin
                    owner_d     = OWN_LS;
                    last_d      = OWN_LS;
                    addr_d      = ls_bus.req_addr;
                    we_d        = ls_bus.req_we;
                    wdata_d     = ls_bus.req_wdata;
                    be_d        = ls_bus.req_be;
                    req_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_bus.req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (mem_bus.resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, owner, round-robin pointer and latched memory request fields.
    // Reset points the pointer at LS so fetch wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_LS;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
        end
    end

    // Ready is the grant itself, only in IDLE and never while reset is held.
    assign if_bus.req_ready = rst_n && in_idle && gnt[GNT_IF];
    assign ls_bus.req_ready = rst_n && in_idle && gnt[GNT_LS];

    assign mem_bus.req_valid = req_valid_q;
    assign mem_bus.req_addr  = addr_q;
    assign mem_bus.req_we    = we_q;
    assign mem_bus.req_wdata = wdata_q;
    assign mem_bus.req_be    = be_q;

    // Responses go only to the slot owner; data is zeroed when not valid.
    assign if_bus.resp_valid = if_resp_hit;
    assign if_bus.resp_data  = if_resp_hit ? mem_bus.resp_data : '0;
    assign ls_bus.resp_valid = ls_resp_hit;
    assign ls_bus.resp_data  = ls_resp_hit ? mem_bus.resp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. The bench plays both requesters and
// the memory; expected transactions go into a scoreboard queue when a request
// is driven and are checked against the memory port and the response port.
module tb_mem_arbiter;
    import cpu_pkg::*;

    localparam int XLEN = 32;
    localparam int BEW  = XLEN / 8;

    typedef struct {
        owner_e          owner;
        logic [XLEN-1:0] addr;
        logic            we;
        logic [XLEN-1:0] wdata;
        logic [BEW-1:0]  be;
        logic [XLEN-1:0] rdata;
    } txn_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b1;
    int     tests_run    = 0;
    int     tests_failed = 0;
    txn_t   exp_q[$];
    owner_e model_last = OWN_LS;

    mem_arbiter_if #(.xlen(XLEN)) if_bus ();
    mem_arbiter_if #(.xlen(XLEN)) ls_bus ();
    mem_arbiter_if #(.xlen(XLEN)) mem_bus ();

    mem_arbiter #(.xlen(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_bus  (if_bus),
        .ls_bus  (ls_bus),
        .mem_bus (mem_bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Fetch side: write fields are driven with junk the arbiter must ignore.
    task automatic drive_if(input logic v, input logic [XLEN-1:0] a);
        if_bus.req_valid = v;
        if_bus.req_addr  = a;
        if_bus.req_we    = 1'b1;
        if_bus.req_wdata = 32'hA5A5_A5A5;
        if_bus.req_be    = '1;
    endtask

    task automatic drive_ls(input logic v, input logic [XLEN-1:0] a, input logic we,
                            input logic [XLEN-1:0] wd, input logic [BEW-1:0] be);
        ls_bus.req_valid = v;
        ls_bus.req_addr  = a;
        ls_bus.req_we    = we;
        ls_bus.req_wdata = wd;
        ls_bus.req_be    = be;
    endtask

    task automatic drive_mem(input logic rdy, input logic rv, input logic [XLEN-1:0] rd);
        mem_bus.req_ready  = rdy;
        mem_bus.resp_valid = rv;
        mem_bus.resp_data  = rd;
    endtask

    // Reference grant choice: lone requester wins, ties go to the last loser.
    function automatic owner_e predict(input logic ifv, input logic lsv);
        if (ifv && lsv) return (model_last == OWN_LS) ? OWN_IF : OWN_LS;
        else if (ifv)   return OWN_IF;
        else            return OWN_LS;
    endfunction

    function automatic txn_t make_txn(input owner_e o, input logic [XLEN-1:0] a, input logic we,
                                      input logic [XLEN-1:0] wd, input logic [BEW-1:0] be,
                                      input logic [XLEN-1:0] rd);
        txn_t t;
        t.owner = o;
        t.addr  = a;
        t.we    = (o == OWN_IF) ? 1'b0 : we;
        t.wdata = wd;
        t.be    = (o == OWN_IF) ? '0 : be;
        t.rdata = rd;
        return t;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_if(1'b0, '0);
        drive_ls(1'b0, '0, 1'b0, '0, '0);
        drive_mem(1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = OWN_LS;
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        drive_if(1'b1, 32'h0000_0100);
        drive_ls(1'b1, 32'h0000_0300, 1'b1, 32'hFFFF_FFFF, 4'hF);
        drive_mem(1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (if_bus.req_ready !== 1'b0 || ls_bus.req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got if=%b ls=%b, expected 0 0", if_bus.req_ready, ls_bus.req_ready);
        end
        tests_run++;
        if (mem_bus.req_valid !== 1'b0 || mem_bus.req_addr !== '0 || mem_bus.req_we !== 1'b0 ||
            mem_bus.req_wdata !== '0 || mem_bus.req_be !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem_fields: got v=%b a=%h we=%b wd=%h be=%h, expected all 0",
                     mem_bus.req_valid, mem_bus.req_addr, mem_bus.req_we, mem_bus.req_wdata, mem_bus.req_be);
        end
        tests_run++;
        if (if_bus.resp_valid !== 1'b0 || ls_bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_resp: got if=%b ls=%b, expected 0 0", if_bus.resp_valid, ls_bus.resp_valid);
        end
        drive_if(1'b0, '0);
        drive_ls(1'b0, '0, 1'b0, '0, '0);
        drive_mem(1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = OWN_LS;
        exp_q.delete();
    endtask

    task automatic test_lone_if();
        txn_t   exp;
        owner_e w;
        @(negedge clk);
        drive_if(1'b1, 32'h0000_0100);
        drive_mem(1'b0, 1'b0, '0);
        w = predict(1'b1, 1'b0);
        exp_q.push_back(make_txn(w, 32'h0000_0100, 1'b0, '0, '0, 32'hDEAD_BEEF));
        #1;
        tests_run++;
        if (if_bus.req_ready !== 1'b1 || ls_bus.req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lone_if_ready: got if=%b ls=%b, expected 1 0", if_bus.req_ready, ls_bus.req_ready);
        end
        model_last = w;
        @(negedge clk);
        drive_if(1'b0, '0);
        drive_mem(1'b1, 1'b0, '0);
        #1;
        exp = exp_q[0];
        tests_run++;
        if (mem_bus.req_valid !== 1'b1 || mem_bus.req_addr !== exp.addr ||
            mem_bus.req_we !== exp.we || mem_bus.req_be !== exp.be) begin
            tests_failed++;
            $display("[TB] FAIL lone_if_issue: got v=%b a=%h we=%b be=%h, expected 1 %h %b %h",
                     mem_bus.req_valid, mem_bus.req_addr, mem_bus.req_we, mem_bus.req_be, exp.addr, exp.we, exp.be);
        end
        @(negedge clk);
        drive_mem(1'b0, 1'b1, exp.rdata);
        #1;
        exp = exp_q.pop_front();
        tests_run++;
        if (if_bus.resp_valid !== 1'b1 || if_bus.resp_data !== exp.rdata || ls_bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lone_if_resp: got if_v=%b data=%h ls_v=%b, expected 1 %h 0",
                     if_bus.resp_valid, if_bus.resp_data, ls_bus.resp_valid, exp.rdata);
        end
        @(negedge clk);
        drive_mem(1'b0, 1'b0, '0);
        #1;
        tests_run++;
        if (if_bus.resp_valid !== 1'b0 || mem_bus.req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lone_if_done: got resp_v=%b mem_v=%b, expected 0 0", if_bus.resp_valid, mem_bus.req_valid);
        end
    endtask

    task automatic test_rr_back_to_back();
        txn_t   exp;
        owner_e w;
        owner_e order [3];
        order[0] = OWN_IF;
        order[1] = OWN_LS;
        order[2] = OWN_IF;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_if(1'b1, 32'h0000_0200);
            drive_ls(1'b1, 32'h0000_0300, 1'b0, '0, '0);
            drive_mem(1'b0, 1'b0, '0);
            w = predict(1'b1, 1'b1);
            exp_q.push_back(make_txn(w, (w == OWN_IF) ? 32'h0000_0200 : 32'h0000_0300,
                                     1'b0, '0, '0, 32'hA000_0000 + k));
            #1;
            tests_run++;
            if (w !== order[k] || if_bus.req_ready !== (w == OWN_IF) || ls_bus.req_ready !== (w == OWN_LS)) begin
                tests_failed++;
                $display("[TB] FAIL rr_grant_%0d: got if=%b ls=%b, expected owner %0d", k,
                         if_bus.req_ready, ls_bus.req_ready, order[k]);
            end
            model_last = w;
            @(negedge clk);
            drive_mem(1'b1, 1'b0, '0);
            #1;
            exp = exp_q[0];
            tests_run++;
            if (mem_bus.req_valid !== 1'b1 || mem_bus.req_addr !== exp.addr ||
                if_bus.req_ready !== 1'b0 || ls_bus.req_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rr_issue_%0d: got v=%b a=%h rdy=%b%b, expected 1 %h 00", k,
                         mem_bus.req_valid, mem_bus.req_addr, if_bus.req_ready, ls_bus.req_ready, exp.addr);
            end
            @(negedge clk);
            drive_mem(1'b0, 1'b1, exp.rdata);
            #1;
            exp = exp_q.pop_front();
            tests_run++;
            if (if_bus.resp_valid !== (exp.owner == OWN_IF) || ls_bus.resp_valid !== (exp.owner == OWN_LS) ||
                ((exp.owner == OWN_IF) ? if_bus.resp_data : ls_bus.resp_data) !== exp.rdata ||
                if_bus.req_ready !== 1'b0 || ls_bus.req_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rr_resp_%0d: got if_v=%b ls_v=%b if_d=%h ls_d=%h, expected owner %0d data %h", k,
                         if_bus.resp_valid, ls_bus.resp_valid, if_bus.resp_data, ls_bus.resp_data, exp.owner, exp.rdata);
            end
        end
    endtask

    task automatic test_store_stall();
        txn_t   exp;
        owner_e w;
        int     pulses;
        @(negedge clk);
        drive_if(1'b0, '0);
        drive_ls(1'b1, 32'h0000_0040, 1'b1, 32'h1234_5678, 4'hF);
        drive_mem(1'b0, 1'b0, '0);
        w = predict(1'b0, 1'b1);
        exp_q.push_back(make_txn(w, 32'h0000_0040, 1'b1, 32'h1234_5678, 4'hF, 32'h0BAD_F00D));
        #1;
        tests_run++;
        if (ls_bus.req_ready !== 1'b1 || if_bus.req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL store_ready: got ls=%b if=%b, expected 1 0", ls_bus.req_ready, if_bus.req_ready);
        end
        model_last = w;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_ls(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0);
            drive_mem(c == 3, 1'b0, '0);
            #1;
            exp = exp_q[0];
            tests_run++;
            if (mem_bus.req_valid !== 1'b1 || mem_bus.req_addr !== exp.addr || mem_bus.req_we !== exp.we ||
                mem_bus.req_wdata !== exp.wdata || mem_bus.req_be !== exp.be || ls_bus.req_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL store_hold_%0d: got v=%b a=%h we=%b wd=%h be=%h rdy=%b, expected 1 %h %b %h %h 0", c,
                         mem_bus.req_valid, mem_bus.req_addr, mem_bus.req_we, mem_bus.req_wdata, mem_bus.req_be,
                         ls_bus.req_ready, exp.addr, exp.we, exp.wdata, exp.be);
            end
        end
        pulses = 0;
        @(negedge clk);
        drive_mem(1'b0, 1'b1, exp.rdata);
        #1;
        exp = exp_q.pop_front();
        if (ls_bus.resp_valid === 1'b1) pulses++;
        tests_run++;
        if (if_bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL store_if_quiet: got if_resp_valid=%b, expected 0", if_bus.resp_valid);
        end
        @(negedge clk);
        drive_ls(1'b0, '0, 1'b0, '0, '0);
        #1;
        if (ls_bus.resp_valid === 1'b1) pulses++;
        @(negedge clk);
        drive_mem(1'b0, 1'b0, '0);
        #1;
        if (ls_bus.resp_valid === 1'b1) pulses++;
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("[TB] FAIL store_resp_pulse: got %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic test_spurious();
        txn_t   exp;
        owner_e w;
        @(negedge clk);
        drive_if(1'b0, '0);
        drive_ls(1'b0, '0, 1'b0, '0, '0);
        drive_mem(1'b0, 1'b1, 32'h1111_1111);
        #1;
        tests_run++;
        if (if_bus.resp_valid !== 1'b0 || ls_bus.resp_valid !== 1'b0 || mem_bus.req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_idle: got if_v=%b ls_v=%b mem_v=%b, expected 0 0 0",
                     if_bus.resp_valid, ls_bus.resp_valid, mem_bus.req_valid);
        end
        @(negedge clk);
        drive_if(1'b1, 32'h0000_0500);
        drive_mem(1'b0, 1'b1, 32'h2222_2222);
        w = predict(1'b1, 1'b0);
        exp_q.push_back(make_txn(w, 32'h0000_0500, 1'b0, '0, '0, 32'h5555_AAAA));
        #1;
        tests_run++;
        if (if_bus.req_ready !== 1'b1 || if_bus.resp_valid !== 1'b0 || ls_bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_accept: got rdy=%b if_v=%b ls_v=%b, expected 1 0 0",
                     if_bus.req_ready, if_bus.resp_valid, ls_bus.resp_valid);
        end
        model_last = w;
        @(negedge clk);
        drive_if(1'b0, '0);
        drive_mem(1'b0, 1'b1, 32'h3333_3333);
        #1;
        tests_run++;
        if (mem_bus.req_valid !== 1'b1 || if_bus.resp_valid !== 1'b0 || ls_bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_issue: got mem_v=%b if_v=%b ls_v=%b, expected 1 0 0",
                     mem_bus.req_valid, if_bus.resp_valid, ls_bus.resp_valid);
        end
        @(negedge clk);
        drive_mem(1'b1, 1'b0, '0);
        #1;
        exp = exp_q[0];
        tests_run++;
        if (mem_bus.req_valid !== 1'b1 || mem_bus.req_addr !== exp.addr) begin
            tests_failed++;
            $display("[TB] FAIL spurious_still_issue: got v=%b a=%h, expected 1 %h",
                     mem_bus.req_valid, mem_bus.req_addr, exp.addr);
        end
        @(negedge clk);
        drive_mem(1'b0, 1'b1, exp.rdata);
        #1;
        exp = exp_q.pop_front();
        tests_run++;
        if (if_bus.resp_valid !== 1'b1 || if_bus.resp_data !== exp.rdata || ls_bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_resp: got if_v=%b data=%h ls_v=%b, expected 1 %h 0",
                     if_bus.resp_valid, if_bus.resp_data, ls_bus.resp_valid, exp.rdata);
        end
    endtask

    task automatic test_reset_mid();
        txn_t   exp;
        owner_e w;
        @(negedge clk);
        drive_if(1'b1, 32'h0000_0600);
        drive_mem(1'b0, 1'b0, '0);
        w = predict(1'b1, 1'b0);
        #1;
        tests_run++;
        if (if_bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_accept: got %b, expected 1", if_bus.req_ready);
        end
        model_last = w;
        @(negedge clk);
        drive_if(1'b0, '0);
        drive_mem(1'b1, 1'b0, '0);
        @(negedge clk);
        drive_mem(1'b0, 1'b0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_bus.req_valid !== 1'b0 || mem_bus.req_addr !== '0 || if_bus.resp_valid !== 1'b0 ||
            ls_bus.resp_valid !== 1'b0 || if_bus.req_ready !== 1'b0 || ls_bus.req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_outputs: got mem_v=%b a=%h if_v=%b ls_v=%b, expected 0 0 0 0",
                     mem_bus.req_valid, mem_bus.req_addr, if_bus.resp_valid, ls_bus.resp_valid);
        end
        model_last = OWN_LS;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_mem(1'b0, 1'b1, 32'hCAFE_CAFE);
        #1;
        tests_run++;
        if (if_bus.resp_valid !== 1'b0 || ls_bus.resp_valid !== 1'b0 || mem_bus.req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_late_resp: got if_v=%b ls_v=%b mem_v=%b, expected 0 0 0",
                     if_bus.resp_valid, ls_bus.resp_valid, mem_bus.req_valid);
        end
        @(negedge clk);
        drive_mem(1'b0, 1'b0, '0);
        drive_if(1'b1, 32'h0000_0700);
        w = predict(1'b1, 1'b0);
        exp_q.push_back(make_txn(w, 32'h0000_0700, 1'b0, '0, '0, 32'h7777_0000));
        #1;
        tests_run++;
        if (if_bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_next_accept: got %b, expected 1", if_bus.req_ready);
        end
        model_last = w;
        @(negedge clk);
        drive_if(1'b0, '0);
        drive_mem(1'b1, 1'b0, '0);
        #1;
        exp = exp_q[0];
        tests_run++;
        if (mem_bus.req_valid !== 1'b1 || mem_bus.req_addr !== exp.addr || mem_bus.req_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_next_issue: got v=%b a=%h we=%b, expected 1 %h 0",
                     mem_bus.req_valid, mem_bus.req_addr, mem_bus.req_we, exp.addr);
        end
        @(negedge clk);
        drive_mem(1'b0, 1'b1, exp.rdata);
        #1;
        exp = exp_q.pop_front();
        tests_run++;
        if (if_bus.resp_valid !== 1'b1 || if_bus.resp_data !== exp.rdata || ls_bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_next_resp: got if_v=%b data=%h ls_v=%b, expected 1 %h 0",
                     if_bus.resp_valid, if_bus.resp_data, ls_bus.resp_valid, exp.rdata);
        end
        @(negedge clk);
        drive_mem(1'b0, 1'b0, '0);
    endtask

    // Test sequence.
    initial begin
        drive_if(1'b0, '0);
        drive_ls(1'b0, '0, 1'b0, '0, '0);
        drive_mem(1'b0, 1'b0, '0);
        test_reset();
        test_lone_if();
        test_rr_back_to_back();
        test_store_stall();
        test_spurious();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: xlen, default 32, data/address width in bits.
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req_valid  input  1  instruction-fetch request pending.
REQ-005 if_req_addr  input  xlen  fetch address.
REQ-006 if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 if_resp_valid  output  1  fetch response data valid.
REQ-008 if_resp_data  output  xlen  fetch response data.
REQ-009 ls_req_valid  input  1  load/store request pending.
REQ-010 ls_req_addr  input  xlen  load/store address.
REQ-011 ls_req_we  input  1  1 = store, 0 = load.
REQ-012 ls_req_wdata  input  xlen  store data.
REQ-013 ls_req_be  input  xlen/8  store byte enables.
REQ-014 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-015 ls_resp_valid  output  1  load data valid / store complete.
REQ-016 ls_resp_data  output  xlen  load response data.
REQ-017 mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be  output  1/xlen/1/xlen/xlen/8  request to shared memory port.
REQ-018 mem_req_ready  input  1  memory accepts the request.
REQ-019 mem_resp_valid  input  1  memory response valid.
REQ-020 mem_resp_data  input  xlen  memory response data.

Function
REQ-021 The block SHALL share one memory port between fetch (IF) and load/store (LS), with at most one transaction outstanding.
REQ-022 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-023 In IDLE, if any request valid: SHALL grant one, assert only that requester's ready for exactly that cycle, latch addr/we/wdata/be and owner, and go to ISSUE.
REQ-024 Simultaneous IF and LS requests SHALL be resolved round-robin: grant the requester not granted last; a lone requester SHALL always be granted.
REQ-025 An IF grant SHALL latch we=0 and be=all-zero.
REQ-026 In ISSUE: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go to WAIT.
REQ-027 In WAIT: on mem_resp_valid=1, assert the owner's resp_valid with resp_data=mem_resp_data in the same cycle (combinational) and return to IDLE; the other resp_valid SHALL stay 0.
REQ-028 Stores SHALL also complete with a response (ls_resp_valid pulse; data don't-care).
REQ-029 mem_resp_valid outside WAIT SHALL be ignored.
REQ-030 Requests SHALL be sampled only in IDLE; ready SHALL be 0 in ISSUE and WAIT.
REQ-031 Minimum latency: accept at cycle T, mem_req_valid at T+1, response no earlier than T+2; back-to-back transactions every 3 cycles minimum.
REQ-032 The last-grant pointer SHALL update only on a grant.

Reset
REQ-033 On rst_n=0: state=IDLE, last-grant=LS (so IF wins the first tie), all valid/ready outputs 0, latched fields 0.
REQ-034 Reset mid-transaction SHALL drop the in-flight request with no response to either requester.

Structure
REQ-035 The state enum, owner enum (OWN_IF, OWN_LS) and xlen default SHALL live in shared package cpu_pkg.
REQ-036 Grant selection SHALL be one sub-module, rr_arb2 (two requests, last-grant input, one-hot grant output).

Verification
REQ-037 Lone IF: addr 0x0000_0100, mem_req_ready=1 at once, response 0xDEAD_BEEF one cycle later -> mem_req_addr=0x100 at T+1, if_resp_data=0xDEAD_BEEF at T+2, ls_resp_valid=0.
REQ-038 Simultaneous IF 0x200 and LS 0x300 held after reset -> IF granted first, then LS; third tie -> IF.
REQ-039 LS store addr 0x40, wdata 0x1234_5678, be 0xF, mem_req_ready low 3 cycles -> fields stable during ISSUE, ls_resp_valid pulses once.
REQ-040 Spurious mem_resp_valid in IDLE and ISSUE -> no resp_valid asserted.
REQ-041 rst_n low during WAIT -> outputs 0 immediately; later mem_resp_valid ignored; next IF request served normally.
